// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-port responder for the single-cycle core.
// Word RAM plus LED, switch, cycle counter and byte output FIFO registers.
module dmem_mmio_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int SW_WIDTH   = 10,
  parameter int LED_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemWrite,
  input  logic [31:0]          Addr,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  input  logic [SW_WIDTH-1:0]  sw,
  output logic [LED_WIDTH-1:0] leds,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  localparam logic [29:0] W_LED  = 30'h400;
  localparam logic [29:0] W_SW   = 30'h401;
  localparam logic [29:0] W_CYC  = 30'h402;
  localparam logic [29:0] W_FIFO = 30'h403;
  localparam logic [29:0] W_STS  = 30'h404;

  logic [31:0]         ram [RAM_WORDS];
  logic [7:0]          fifo_mem [FIFO_DEPTH];

  logic [31:0]         cycle;
  logic [SW_WIDTH-1:0] sw_q1;
  logic [SW_WIDTH-1:0] sw_q2;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       count;

  logic [29:0]   word;
  logic [AW-1:0] ram_idx;
  logic          aligned;
  logic          in_ram;
  logic          hit_led;
  logic          hit_sw;
  logic          hit_cyc;
  logic          hit_fifo;
  logic          hit_sts;
  logic          wr_ok;
  logic          ram_we;
  logic          led_we;
  logic          cyc_clr;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          drop;
  logic          wr_bad;
  logic [31:0]   led_ext;
  logic [31:0]   sw_ext;
  logic [31:0]   status;

  assign word    = Addr[31:2];
  assign ram_idx = Addr[AW+1:2];
  assign aligned = (Addr[1:0] == 2'b00);
  assign in_ram  = ({1'b0, Addr} < RAM_BYTES);

  // MMIO hits only outside RAM so decode stays one-hot.
  assign hit_led  = !in_ram && (word == W_LED);
  assign hit_sw   = !in_ram && (word == W_SW);
  assign hit_cyc  = !in_ram && (word == W_CYC);
  assign hit_fifo = !in_ram && (word == W_FIFO);
  assign hit_sts  = !in_ram && (word == W_STS);

  assign wr_ok    = MemWrite && aligned;
  assign ram_we   = wr_ok && in_ram;
  assign led_we   = wr_ok && hit_led;
  assign cyc_clr  = wr_ok && hit_cyc;
  assign push_req = wr_ok && hit_fifo;

  assign wr_bad = MemWrite &&
    (!aligned || !(in_ram || hit_led || hit_cyc || hit_fifo));

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 8'd0;

  assign led_ext = 32'(leds);
  assign sw_ext  = 32'(sw_q2);
  assign status  = {16'd0, 8'(count), 6'd0, empty, full};

  // Load data mux: zero-latency read of RAM or MMIO.
  always_comb begin
    ReadData = '0;
    unique case (1'b1)
      in_ram:  ReadData = ram[ram_idx];
      hit_led: ReadData = led_ext;
      hit_sw:  ReadData = sw_ext;
      hit_cyc: ReadData = cycle;
      hit_sts: ReadData = status;
      default: ReadData = '0;
    endcase
  end

  // Data RAM storage, contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= WriteData;
  end

  // FIFO byte storage; head is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= WriteData[7:0];
  end

  // Control registers, sync flops, counter and FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds   <= '0;
      cycle  <= '0;
      sw_q1  <= '0;
      sw_q2  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      sw_q1 <= sw;
      sw_q2 <= sw_q1;
      cycle <= cyc_clr ? 32'd0 : cycle + 32'd1;
      if (led_we) leds <= WriteData[LED_WIDTH-1:0];
      if (wr_bad || drop) err <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Memory-side responder for the single-cycle ARM core's data port; it decodes the core's address (ALUResult), MemWrite, WriteData and ReadData.
- Provides word-addressed data RAM plus a small MMIO bank: LED register, synchronized switches, cycle counter and a byte output FIFO with a valid/ready consumer port.
- Sits beside the core in the top level, opposite the core's load/store interface.

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words, mapped at byte address 0x0000_0000 upward.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.
- SW_WIDTH, 10, switch input width.
- LED_WIDTH, 10, LED output width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- MemWrite  in  1  store strobe from core; write commits at the rising edge.
- Addr  in  32  byte address (core ALUResult).
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from Addr and current state.
- sw  in  SW_WIDTH  asynchronous switch inputs.
- leds  out  LED_WIDTH  LED register.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head byte.
- err  out  1  sticky bus-error flag.

Behaviour:
- Reset (reset=0, async) clears: leds=0, counter=0, FIFO pointers and count (out_valid=0, out_data=0), sw sync flops=0, err=0.
  - RAM contents are not reset.
  - Reset mid-transfer discards all FIFO contents.
- Address decode uses Addr[31:2]; Addr[1:0] is ignored for reads.
- A write with Addr[1:0]!=0 is dropped and sets err.
- RAM region (Addr < RAM_WORDS*4):
  - Read: ReadData=RAM[Addr[..:2]], combinational, zero latency.
  - Write: RAM word updated at the edge when MemWrite=1.
  - Read-after-write to the same word returns the new data in the next cycle.
- MMIO map (all other reads return 0):
  - 0x1000 LED, RW. Write loads leds<=WriteData[LED_WIDTH-1:0]. Read returns leds zero-extended.
  - 0x1004 SW, RO. Read returns the 2-flop-synchronized sw, zero-extended, so a pin change is visible 2 edges later.
  - 0x1008 CYCLE, RO-clear. 32-bit free-running counter, +1 every edge, wraps 0xFFFF_FFFF->0. Any write forces it to 0 at that edge; increment is suppressed that edge.
  - 0x100C FIFO_DATA, WO. Write pushes WriteData[7:0]. Read returns 0.
  - 0x1010 FIFO_STATUS, RO. bit0=full, bit1=empty, bits[15:8]=count, other bits 0.
- Write to an RO register, or to an address outside RAM and MMIO: no state change, err<=1.
- FIFO rules:
  - pop = out_valid & out_ready.
  - push = write to 0x100C.
  - out_data = head entry when out_valid=1, else 0. No fall-through: a push into an empty FIFO raises out_valid at the next edge.
  - Simultaneous push+pop, non-empty: both happen, count unchanged. This includes the full case: the push is accepted because the pop frees a slot.
  - Simultaneous push+pop, empty: pop is not possible (out_valid=0); push proceeds.
  - Push when full and no pop: byte dropped, err<=1.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- err clears only on reset.
- No core stalls; every access completes in one cycle.

Test Plan:
- Write 0x12345678 to 0x0040, then read 0x0040 and 0x0042 -> both return 0x12345678. Read 0x0044 (never written after init) returns the RAM initial value.
- Write 0x3FF to 0x1000 -> leds=0x3FF next cycle, reading 0x1000 returns 0x000003FF. Write to 0x1004 -> err=1, leds unchanged.
- Set sw=0x155 at edge n -> reading 0x1004 returns 0 before edge n+2, and 0x155 from edge n+2 onward.
- Release reset, read 0x1008 after 5 edges -> 5. Write to 0x1008 -> next read 0, one cycle later 1. Preload to wrap -> 0xFFFF_FFFF then 0.
- out_ready=0, push 0x41..0x48 (8 bytes) -> status full=1, count=8. Push 0x49 -> dropped, err=1. Then out_ready=1 -> out_data sequence 0x41..0x48, one per cycle, then out_valid=0 and status empty=1.
- With FIFO full and out_ready=1, push 0x50 in the same cycle as a pop -> count stays 8, err unchanged, and 0x50 emerges last. Assert reset with 3 bytes queued -> out_valid=0 immediately (async).
